// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-button FSM states,
// button indices and default timing constants (100 MHz clock).
package btn_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_REPEATING    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_START = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;

  localparam int DEF_DB_CYCLES  = 1000000;
  localparam int DEF_RPT_DELAY  = 50000000;
  localparam int DEF_RPT_PERIOD = 10000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit above the largest terminal count so no state can wrap.
  function automatic int cnt_width(input int db, input int rd, input int rp);
    return $clog2(max3(db, rd, rp)) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_one.sv
// One button: 2-flop synchronizer, debounce/auto-repeat FSM and its private
// counter. All outputs come straight from flops.
module btn_debounce_one
  import btn_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse,
  output logic o_repeat
);

  localparam int CNT_W = cnt_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(RPT_PERIOD - 1);

  logic             r_s1, r_s2;
  btn_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, r_pulse, r_repeat;
  logic             w_level_nxt, w_pulse_nxt, w_repeat_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_pulse_nxt  = 1'b0;
    w_repeat_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_s2) w_state_nxt = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!r_s2) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt  = ST_PRESSED;
          w_pulse_nxt  = 1'b1;
          w_repeat_nxt = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!r_s2) begin
          w_state_nxt = ST_RELEASE_WAIT;
        end else if (r_cnt == RD_LAST) begin
          w_state_nxt  = ST_REPEATING;
          w_repeat_nxt = 1'b1;
        end
      end
      ST_REPEATING: begin
        if (!r_s2) begin
          w_state_nxt = ST_RELEASE_WAIT;
        end else if (r_cnt == RP_LAST) begin
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        // A short dip while held lands back in PRESSED silently; repeat timing restarts.
        if (r_s2)                  w_state_nxt = ST_PRESSED;
        else if (r_cnt == DB_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    w_level_nxt = (w_state_nxt inside {ST_PRESSED, ST_REPEATING, ST_RELEASE_WAIT});
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_pulse  <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_pulse  <= w_pulse_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  assign o_level  = r_level;
  assign o_pulse  = r_pulse;
  assign o_repeat = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// Four independent button conditioners (Start, Left, Right, Down). The game
// logic uses btn_pulse for Start/Down and btn_repeat for Left/Right.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse,
  output logic [NUM_BTNS-1:0] btn_repeat
);

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce_one #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_btn (
      .i_clk   (Clk),
      .i_rst_n (Reset_n),
      .i_raw   (btn_raw[g]),
      .o_level (btn_level[g]),
      .o_pulse (btn_pulse[g]),
      .o_repeat(btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with short timing (DB=4, delay=8, period=3):
// table of press scenarios, hand-written corner sequences, random stimulus.
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level, btn_pulse, btn_repeat;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .btn_repeat(btn_repeat)
  );

  always #5 Clk = ~Clk;

  // Reference model: a press is accepted once the synchronized input has
  // disagreed with the accepted level for DB+1 consecutive samples; repeats
  // fall at hold time RD, RD+RP, ... measured from the last unbroken hold start.
  typedef struct {
    logic [3:0] h1, h2, lvl, pulse, rpt;
    int         run  [4];
    int         hold [4];
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.h1 = '0; n.h2 = '0; n.lvl = '0; n.pulse = '0; n.rpt = '0;
    for (int b = 0; b < 4; b++) begin
      n.run[b]  = 0;
      n.hold[b] = -1;
    end
    return n;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [3:0] raw);
    mdl_t n;
    logic sy;
    n = s;
    n.pulse = '0;
    n.rpt   = '0;
    for (int b = 0; b < 4; b++) begin
      sy = s.h2[b];
      if (!s.lvl[b]) begin
        n.run[b] = sy ? s.run[b] + 1 : 0;
        if (n.run[b] == DB + 1) begin
          n.lvl[b] = 1'b1; n.run[b] = 0; n.pulse[b] = 1'b1; n.rpt[b] = 1'b1; n.hold[b] = 0;
        end
      end else if (!sy) begin
        n.run[b]  = s.run[b] + 1;
        n.hold[b] = -1;
        if (n.run[b] == DB + 1) begin
          n.lvl[b] = 1'b0; n.run[b] = 0;
        end
      end else begin
        n.run[b] = 0;
        if (s.hold[b] < 0) n.hold[b] = 0;
        else begin
          n.hold[b] = s.hold[b] + 1;
          if (n.hold[b] >= RD && (n.hold[b] - RD) % RP == 0) n.rpt[b] = 1'b1;
        end
      end
    end
    n.h2 = s.h1;
    n.h1 = raw;
    return n;
  endfunction

  mdl_t m;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m <= mdl_reset();
    else          m <= mdl_step(m, btn_raw);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model_level",  32'(btn_level),  32'(m.lvl));
    chk("model_pulse",  32'(btn_pulse),  32'(m.pulse));
    chk("model_repeat", 32'(btn_repeat), 32'(m.rpt));
  endtask

  // Starts and ends on a falling edge; inputs change only there.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    cmp_model();
  endtask

  task automatic pulse_reset(input int low_cycles);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_async_level",  32'(btn_level),  0);
    chk("rst_async_pulse",  32'(btn_pulse),  0);
    chk("rst_async_repeat", 32'(btn_repeat), 0);
    @(negedge Clk);
    cmp_model();
    for (int i = 0; i < low_cycles; i++) tick();
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
    cmp_model();
  endtask

  task automatic idle(input int n);
    btn_raw = 4'b0000;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    string      name;
    logic [3:0] btns;
    int         hold;    // cycles raw is held high
    int         pat;     // expected pulse cycle, -1 if none
    int         npulse;
    int         nrep;
    int         nlvl;    // cycles with level high
  } vec_t;

  vec_t tbl[7];

  task automatic run_entry(input vec_t v);
    int pcnt[4], rcnt[4], lcnt[4], pat[4], rt1[4], rt2[4];
    for (int b = 0; b < 4; b++) begin
      pcnt[b] = 0; rcnt[b] = 0; lcnt[b] = 0; pat[b] = -1; rt1[b] = -1; rt2[b] = -1;
    end
    btn_raw = v.btns;
    for (int c = 0; c < v.hold + 14; c++) begin
      tick();
      for (int b = 0; b < 4; b++) begin
        if (btn_pulse[b]) begin
          if (pat[b] < 0) pat[b] = c;
          pcnt[b]++;
        end
        if (btn_repeat[b]) begin
          if (rcnt[b] == 1) rt1[b] = c;
          if (rcnt[b] == 2) rt2[b] = c;
          rcnt[b]++;
        end
        if (btn_level[b]) lcnt[b]++;
      end
      if (c == v.hold - 1) btn_raw = 4'b0000;
    end
    for (int b = 0; b < 4; b++) begin
      if (v.btns[b]) begin
        chk({v.name, "_pulse_cnt"}, pcnt[b], v.npulse);
        chk({v.name, "_pulse_at"},  pat[b],  v.pat);
        chk({v.name, "_rep_cnt"},   rcnt[b], v.nrep);
        chk({v.name, "_lvl_cnt"},   lcnt[b], v.nlvl);
        if (v.nrep >= 3) begin
          chk({v.name, "_rep1_at"}, rt1[b], v.pat + RD);
          chk({v.name, "_rep2_at"}, rt2[b], v.pat + RD + RP);
        end
      end else begin
        chk({v.name, "_idle_pulse"}, pcnt[b], 0);
        chk({v.name, "_idle_lvl"},   lcnt[b], 0);
      end
    end
    chk({v.name, "_end_level"}, 32'(btn_level), 0);
  endtask

  int rleft[4];
  logic [3:0] rlv;

  initial begin
    int pc, pat, rc, r1, lc;

    tbl[0] = '{"clean3",    4'b1000, 20,  6, 1, 4, 20};
    tbl[1] = '{"repeat2",   4'b0100, 30,  6, 1, 7, 30};
    tbl[2] = '{"concur03",  4'b1001, 10,  6, 1, 1, 10};
    tbl[3] = '{"short1",    4'b0010,  3, -1, 0, 0,  0};
    tbl[4] = '{"minhold0",  4'b0001,  5,  6, 1, 1,  5};
    tbl[5] = '{"short_all", 4'b1111,  4, -1, 0, 0,  0};
    tbl[6] = '{"all4",      4'b1111, 16,  6, 1, 3, 16};

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_level",  32'(btn_level),  0);
    chk("reset_pulse",  32'(btn_pulse),  0);
    chk("reset_repeat", 32'(btn_repeat), 0);
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
    idle(4);

    foreach (tbl[i]) run_entry(tbl[i]);

    // Bounce on Left: 1100110011 then steady high; final rise at cycle 8.
    pc = 0; pat = -1;
    for (int c = 0; c < 30; c++) begin
      btn_raw[1] = ((c / 2) % 2 == 0) || (c >= 10);
      tick();
      if (btn_pulse[1]) begin
        if (pat < 0) pat = c;
        pc++;
      end
    end
    chk("bounce_pulse_cnt", pc, 1);
    chk("bounce_pulse_at",  pat, 14);
    idle(12);

    // Release glitch on Left: 2-cycle dip after acceptance restarts repeat timing.
    pc = 0; rc = 0; r1 = -1; lc = 0;
    btn_raw = 4'b0010;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (btn_pulse[1]) pc++;
      if (btn_repeat[1]) begin
        if (rc == 1) r1 = c;
        rc++;
      end
      if (c >= 6 && btn_level[1]) lc++;
      if (c == 9)  btn_raw[1] = 1'b0;
      if (c == 11) btn_raw[1] = 1'b1;
    end
    chk("glitch_pulse_cnt", pc, 1);
    chk("glitch_lvl_held",  lc, 19);
    chk("glitch_rep_cnt",   rc, 2);
    chk("glitch_rep1_at",   r1, 22);
    idle(12);

    // Reset while Right is auto-repeating, button kept held.
    btn_raw = 4'b0100;
    for (int c = 0; c < 18; c++) tick();
    pulse_reset(2);
    pc = 0; pat = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (btn_pulse[2]) begin
        if (pat < 0) pat = c;
        pc++;
      end
    end
    chk("rst_hold_pulse_cnt", pc, 1);
    chk("rst_hold_pulse_at",  pat, 6);
    idle(12);

    // Random per-button levels with random durations, occasional resets.
    for (int b = 0; b < 4; b++) rleft[b] = 0;
    rlv = 4'b0000;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (rleft[b] == 0) begin
          rlv[b]   = 1'($urandom_range(0, 1));
          rleft[b] = int'($urandom_range(1, 24));
        end
        rleft[b]--;
      end
      btn_raw = rlv;
      if ($urandom_range(0, 399) == 0) pulse_reset(1);
      else tick();
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter: DB_CYCLES, default 1000000, number of stable-sample clocks required to accept a press or release (10 ms at 100 MHz).
REQ-002 Parameter: RPT_DELAY, default 50000000, clocks from press acceptance to the first auto-repeat pulse.
REQ-003 Parameter: RPT_PERIOD, default 10000000, clocks between subsequent auto-repeat pulses.
REQ-004 Port: Clk  input  1  system clock; single clock domain.
REQ-005 Port: Reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: btn_raw  input  4  raw asynchronous buttons; bit0 Start, bit1 Left, bit2 Right, bit3 Down; 1 = pressed.
REQ-007 Port: btn_level  output  4  debounced level per button.
REQ-008 Port: btn_pulse  output  4  one-clock pulse per accepted press.
REQ-009 Port: btn_repeat  output  4  one-clock pulse on accepted press plus auto-repeat while held.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer; the FSM sees only the synchronized bit (sync).
REQ-011 Each button SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED, REPEATING and RELEASE_WAIT, plus a private counter.
REQ-012 IDLE: sync=1 -> PRESS_WAIT with counter cleared; otherwise stay.
REQ-013 PRESS_WAIT: sync=0 -> IDLE, no output; counter==DB_CYCLES-1 with sync=1 -> PRESSED, with btn_pulse and btn_repeat asserted for exactly the first cycle in PRESSED.
REQ-014 PRESSED: sync=0 -> RELEASE_WAIT; counter==RPT_DELAY-1 -> REPEATING, with btn_repeat asserted for one cycle.
REQ-015 REPEATING: every RPT_PERIOD clocks -> assert btn_repeat for one cycle; sync=0 -> RELEASE_WAIT.
REQ-016 RELEASE_WAIT: sync=1 -> PRESSED, counter cleared, no pulse (glitch rejection, repeat timing restarts); counter==DB_CYCLES-1 with sync=0 -> IDLE.
REQ-017 btn_level SHALL be 1 in PRESSED, REPEATING and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-018 Latency: raw rises before edge k and stays high -> btn_pulse is high in the cycle following edge k+DB_CYCLES+2.
REQ-019 The counter SHALL clear on every state change.
REQ-020 The counter SHALL be ceil(log2(max(DB_CYCLES,RPT_DELAY,RPT_PERIOD)))+1 bits wide and never wrap within a state.
REQ-021 btn_pulse SHALL fire at most once per accepted press; holding a button SHALL never re-fire btn_pulse.
REQ-022 Simultaneous presses on several buttons SHALL be handled independently, with no priority and no cross-suppression.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 Reset_n low SHALL asynchronously force all FSMs to IDLE, all counters and synchronizer flops to 0, and btn_level, btn_pulse and btn_repeat to 4'b0000.
REQ-025 Reset asserted mid-press SHALL discard the press; after release of reset, a still-held button SHALL be re-debounced from IDLE and produce exactly one btn_pulse.
REQ-026 Reset deassertion SHALL take effect on the next Clk edge; outputs SHALL not glitch high during reset.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the button index constants (BTN_START=0, BTN_LEFT=1, BTN_RIGHT=2, BTN_DOWN=3) and the default timing constants.
REQ-028 The per-button synchronizer, FSM and counter SHALL be one sub-module, btn_debounce_one, instantiated 4 times by btn_conditioner.
REQ-029 The game FSM SHALL consume btn_pulse for Start/Down and btn_repeat for Left/Right.

Verification (DB_CYCLES=4, RPT_DELAY=8, RPT_PERIOD=3)
REQ-030 Clean press: btn_raw[3] rises and holds 20 clocks -> btn_pulse[3] high exactly 1 cycle, 6 clocks after the rise; btn_level[3]=1.
REQ-031 Bounce: btn_raw[1] toggles every 2 clocks for 10 clocks, then holds high -> exactly one btn_pulse[1], 6 clocks after the final rise.
REQ-032 Auto-repeat: hold btn_raw[2] 30 clocks -> btn_repeat[2] pulses at press acceptance (T), T+8, T+11, T+14, ...; btn_pulse[2] only at T.
REQ-033 Release glitch: while held, drop btn_raw[1] low for 2 clocks -> btn_level stays 1, with no new btn_pulse.
REQ-034 Reset mid-hold: assert Reset_n low during REPEATING with the button held -> all outputs 0 immediately; after Reset_n high, one btn_pulse 6 clocks later.
REQ-035 Concurrency: raise btn_raw[0] and btn_raw[3] on the same edge -> btn_pulse[0] and btn_pulse[3] high in the same cycle.
